// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;
  localparam int COL_W  = 2;
  localparam int CODE_W = 4;

  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef logic [1:0] state_t;
  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t PRESSED  = 2'd2;

  // Indexed by {row, col}: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "E 0 F D"
  localparam logic [15:0][CODE_W-1:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_low_row(input logic [3:0] row_n);
    lowest_low_row = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_n[i]) lowest_low_row = 2'(i);
  endfunction
endpackage

// File: rtl/keypad_scan_timer.sv
// Free-running column slot divider; tick_o marks the last cycle of each slot.
module keypad_scan_timer #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_q;

  assign tick_o = (div_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       div_q <= '0;
    else if (tick_o) div_q <= '0;
    else             div_q <= div_q + DW'(1);
  end
endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobe, debounce FSM, key events and 16-bit operand shifter.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 100000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_DELAY     = 40,
  parameter int REPEAT_RATE      = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  input  logic        OPERAND_CLR,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_VALID,
  output logic        KEY_HELD,
  output logic [15:0] OPERAND
);
  localparam int CW = (DEBOUNCE_SAMPLES < 1) ? 1 : $clog2(DEBOUNCE_SAMPLES + 1);

  logic              tick;
  logic [3:0]        row_s1_q, row_s2_q;
  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_sel_q, col_sel_d;
  logic [1:0]        cand_q, cand_d, ev_row;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ev;
  logic [CODE_W-1:0] ev_code, key_code_q;
  logic              key_valid_q;
  logic [15:0]       operand_q;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_o(tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= ROW;
      row_s2_q <= row_s1_q;
    end
  end

  assign ev_row  = (state_q == SCAN) ? lowest_low_row(row_s2_q) : cand_q;
  assign ev_code = KEY_MAP[{ev_row, col_sel_q}];

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] hold_q, hold_d;
  logic        rep_q, rep_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_sel_d = col_sel_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    ev        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!(&row_s2_q)) begin
            cand_d = lowest_low_row(row_s2_q);
            if (DEBOUNCE_SAMPLES == 1) begin
              state_d = PRESSED;
              cnt_d   = '0;
              ev      = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end else begin
            col_sel_d = col_sel_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_s2_q[cand_q]) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE_SAMPLES)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              ev      = 1'b1;
            end
          end else begin
            // Bounce: give up on this column and move on
            state_d   = SCAN;
            col_sel_d = col_sel_q + 1'b1;
          end
        end
        PRESSED: begin
          if (&row_s2_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE_SAMPLES)) begin
              state_d = SCAN;
              cnt_d   = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            hold_d = '0;
            rep_d  = 1'b0;
`endif
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            hold_d = hold_q + 16'd1;
            if (hold_d == (rep_q ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY))) begin
              ev     = 1'b1;
              hold_d = '0;
              rep_d  = 1'b1;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
`ifdef KEYPAD_REPEAT_EN
      if (state_q != PRESSED) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= SCAN;
      col_sel_q   <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      operand_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_sel_q   <= col_sel_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= ev;
      if (ev) key_code_q <= ev_code;
      if (OPERAND_CLR)
        operand_q <= ev ? {12'h000, ev_code} : 16'h0000;
      else if (ev)
        operand_q <= {operand_q[11:0], ev_code};
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign COL       = ~(4'b0001 << col_sel_q);
  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = (state_q == PRESSED);
  assign OPERAND   = operand_q;
endmodule
